// File: rtl/aurora_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aurora_frame_checker                                         |
// | Description : Aurora 8B/10B RX LocalLink frame checker. Checks SOF/EOF     |
// |               framing, frame length and an LFSR payload pattern. Reports   |
// |               1-cycle DATA_ERR / FRAME_ERR pulses and a saturating count.  |
// | Option      : FRAME_CHK_STATS_EN adds FRAME_COUNT and LAST_LEN outputs.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aurora_frame_checker #(
  parameter logic [15:0] SEED            = 16'hD5E6,
  parameter int unsigned MAX_FRAME_WORDS = 256,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 USER_CLK,
  input  logic                 RESET,
  input  logic                 CHANNEL_UP,
  input  logic [0:15]          RX_D,
  input  logic                 RX_REM,
  input  logic                 RX_SRC_RDY_N,
  input  logic                 RX_SOF_N,
  input  logic                 RX_EOF_N,
  output logic                 DATA_ERR,
  output logic                 FRAME_ERR,
  output logic [0:ERR_CNT_W-1] ERR_COUNT
`ifdef FRAME_CHK_STATS_EN
  ,
  output logic [0:15]          FRAME_COUNT,
  output logic [0:15]          LAST_LEN
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_INFRAME = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [15:0]            lfsr;
  logic [15:0]            lfsr_nxt;
  logic [15:0]            word_cnt;
  logic [15:0]            word_cnt_nxt;
  logic [15:0]            cnt_inc;
  logic                   len_flag;
  logic                   len_flag_nxt;
  logic                   data_err_nxt;
  logic                   frame_err_nxt;
  logic [ERR_CNT_W-1:0]   err_cnt;
  logic [15:0]            rx_word;
  logic                   beat;
  logic                   sof;
  logic                   eof;

  // RX_D[0] is the MSB of the word, so byte 0 lands in rx_word[15:8].
  assign rx_word   = RX_D;
  assign beat      = CHANNEL_UP & ~RX_SRC_RDY_N;
  assign sof       = ~RX_SOF_N;
  assign eof       = ~RX_EOF_N;
  assign ERR_COUNT = err_cnt;

  // Word counter saturates so very long frames cannot alias back to short ones.
  assign cnt_inc = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
  endfunction

  // A short EOF beat (RX_REM=0) only carries byte 0, so byte 1 is ignored.
  function automatic logic word_mismatch(input logic [15:0] exp_w, input logic [15:0] act_w,
                                         input logic last, input logic rem);
    if (last && !rem) begin
      return act_w[15:8] != exp_w[15:8];
    end
    return act_w != exp_w;
  endfunction

  // Next-state, LFSR tracking, length policing and error detection.
  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    word_cnt_nxt  = word_cnt;
    len_flag_nxt  = len_flag;
    data_err_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    if (!CHANNEL_UP) begin
      state_nxt    = ST_IDLE;
      lfsr_nxt     = SEED;
      word_cnt_nxt = 16'd0;
      len_flag_nxt = 1'b0;
    end else if (beat) begin
      if (sof) begin
        // A SOF always restarts the frame; inside a frame it is also a framing error.
        frame_err_nxt = (state == ST_INFRAME);
        data_err_nxt  = word_mismatch(SEED, rx_word, eof, RX_REM);
        lfsr_nxt      = lfsr_step(SEED);
        word_cnt_nxt  = 16'd1;
        len_flag_nxt  = 1'b0;
        state_nxt     = eof ? ST_IDLE : ST_INFRAME;
      end else if (state == ST_IDLE) begin
        // Payload outside a frame: data cannot be checked, only flagged.
        frame_err_nxt = 1'b1;
      end else begin
        data_err_nxt = word_mismatch(lfsr, rx_word, eof, RX_REM);
        lfsr_nxt     = lfsr_step(lfsr);
        word_cnt_nxt = cnt_inc;
        if ((32'(cnt_inc) > MAX_FRAME_WORDS) && !len_flag) begin
          frame_err_nxt = 1'b1;
          len_flag_nxt  = 1'b1;
        end
        if (eof) begin
          state_nxt    = ST_IDLE;
          len_flag_nxt = 1'b0;
        end
      end
    end
  end

  // State, LFSR, counters and registered error pulses.
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      lfsr      <= SEED;
      word_cnt  <= 16'd0;
      len_flag  <= 1'b0;
      DATA_ERR  <= 1'b0;
      FRAME_ERR <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      word_cnt  <= word_cnt_nxt;
      len_flag  <= len_flag_nxt;
      DATA_ERR  <= data_err_nxt;
      FRAME_ERR <= frame_err_nxt;
      if ((data_err_nxt || frame_err_nxt) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

`ifdef FRAME_CHK_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] last_len;
  logic        frame_done;
  logic [15:0] done_len;

  assign FRAME_COUNT = frame_cnt;
  assign LAST_LEN    = last_len;

  // A frame completes on an EOF beat that either starts a frame or lies inside one.
  assign frame_done = beat & eof & (sof | (state == ST_INFRAME));
  assign done_len   = sof ? 16'd1 : cnt_inc;

  // Completed-frame statistics; frames cannot complete while the channel is down.
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      frame_cnt <= 16'd0;
      last_len  <= 16'd0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
      last_len  <= done_len;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aurora_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aurora_frame_checker                                      |
// | Description : Directed, table-driven bench for aurora_frame_checker.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_aurora_frame_checker;

  localparam logic [15:0] SEED = 16'hD5E6;
  localparam int          CW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          chan_up;
  logic [0:15]   rx_d;
  logic          rem;
  logic          src_rdy_n;
  logic          sof_n;
  logic          eof_n;
  logic          data_err;
  logic          frame_err;
  logic [0:CW-1] err_count;
`ifdef FRAME_CHK_STATS_EN
  logic [0:15]   frame_count;
  logic [0:15]   last_len;
`endif

  int checks = 0;
  int errors = 0;

  aurora_frame_checker #(
    .SEED            (SEED),
    .MAX_FRAME_WORDS (256),
    .ERR_CNT_W       (CW)
  ) dut (
    .USER_CLK     (clk),
    .RESET        (rst),
    .CHANNEL_UP   (chan_up),
    .RX_D         (rx_d),
    .RX_REM       (rem),
    .RX_SRC_RDY_N (src_rdy_n),
    .RX_SOF_N     (sof_n),
    .RX_EOF_N     (eof_n),
    .DATA_ERR     (data_err),
    .FRAME_ERR    (frame_err),
    .ERR_COUNT    (err_count)
`ifdef FRAME_CHK_STATS_EN
    ,
    .FRAME_COUNT  (frame_count),
    .LAST_LEN     (last_len)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic        e;
    logic        r;
    logic [15:0] d;
    logic        xd;
    logic        xf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the pulses produced by that cycle.
  task automatic beat(input logic v, input logic s, input logic e, input logic r,
                      input logic [15:0] d, input logic xd, input logic xf, input string name);
    src_rdy_n = ~v;
    sof_n     = ~s;
    eof_n     = ~e;
    rem       = r;
    rx_d      = d;
    @(posedge clk);
    #1;
    check({name, "_data_err"}, {31'd0, data_err}, {31'd0, xd});
    check({name, "_frame_err"}, {31'd0, frame_err}, {31'd0, xf});
    src_rdy_n = 1'b1;
    sof_n     = 1'b1;
    eof_n     = 1'b1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    src_rdy_n = 1'b1;
    sof_n     = 1'b1;
    eof_n     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic add(input logic v, input logic s, input logic e, input logic r,
                     input logic [15:0] d, input logic xd, input logic xf);
    vec_t t;
    t = '{v: v, s: s, e: e, r: r, d: d, xd: xd, xf: xf};
    tbl.push_back(t);
  endtask

  initial begin
    logic [15:0] l0, l1, l2, l3, lw, bad;
    int          exp_cnt;

    l0 = SEED;
    l1 = nxt(l0);
    l2 = nxt(l1);
    l3 = nxt(l2);

    // Clean 4-word frame.
    add(1, 1, 0, 1, l0, 0, 0);
    add(1, 0, 0, 1, l1, 0, 0);
    add(1, 0, 0, 1, l2, 0, 0);
    add(1, 0, 1, 1, l3, 0, 0);
    // Idle cycle with garbage on the bus.
    add(0, 1, 1, 0, 16'hFFFF, 0, 0);
    // Same frame, word 2 corrupted in bit 0.
    add(1, 1, 0, 1, l0, 0, 0);
    add(1, 0, 0, 1, l1, 0, 0);
    add(1, 0, 0, 1, l2 ^ 16'h0001, 1, 0);
    add(1, 0, 1, 1, l3, 0, 0);
    // Beat outside a frame, then SOF twice.
    add(1, 0, 0, 1, 16'h1234, 0, 1);
    add(1, 1, 0, 1, l0, 0, 0);
    add(1, 1, 0, 1, l0, 0, 1);
    add(1, 0, 1, 1, l1, 0, 0);
    // Single-word frames and the RX_REM byte mask.
    add(1, 1, 1, 1, l0, 0, 0);
    bad = {l0[15:8], ~l0[7:0]};
    add(1, 1, 1, 0, bad, 0, 0);
    add(1, 1, 1, 0, l0 ^ 16'h0100, 1, 0);
    add(1, 1, 1, 1, l0 ^ 16'h0001, 1, 0);
    // SOF+EOF inside a frame ends it; the following beat is outside a frame.
    add(1, 1, 0, 1, l0, 0, 0);
    add(1, 1, 1, 1, l0, 0, 1);
    add(1, 0, 0, 1, l1, 0, 1);

    chan_up   = 1'b1;
    rx_d      = 16'h0000;
    rem       = 1'b1;
    do_reset();
    do_reset();
    check("reset_data_err", {31'd0, data_err}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_err_count", {24'd0, err_count}, 32'd0);
`ifdef FRAME_CHK_STATS_EN
    check("reset_frame_count", {16'd0, frame_count}, 32'd0);
    check("reset_last_len", {16'd0, last_len}, 32'd0);
`endif

    // Table-driven vectors with a running error-count model.
    exp_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      beat(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].r, tbl[i].d, tbl[i].xd, tbl[i].xf, $sformatf("vec%0d", i));
      if (tbl[i].xd || tbl[i].xf) exp_cnt++;
      check($sformatf("vec%0d_err_count", i), {24'd0, err_count}, exp_cnt);
    end

    // Length limit: 256 words are fine, word 257 of the next frame is flagged once.
    do_reset();
    lw = SEED;
    for (int k = 0; k < 256; k++) begin
      beat(1, k == 0, k == 255, 1, lw, 0, 0, "len256");
      lw = nxt(lw);
    end
    lw = SEED;
    for (int k = 0; k < 257; k++) begin
      beat(1, k == 0, k == 256, 1, lw, 0, k == 256, "len257");
      lw = nxt(lw);
    end
    check("len_err_count", {24'd0, err_count}, 32'd1);

    // Saturation of the error counter, then a short EOF with a bad byte 1.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      beat(1, 0, 0, 1, 16'hA5A5, 0, 1, "sat");
    end
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    beat(0, 0, 0, 1, 16'h0000, 0, 0, "sat_idle");
    beat(1, 1, 0, 1, l0, 0, 0, "rem0_w0");
    bad = {l1[15:8], ~l1[7:0]};
    beat(1, 0, 1, 0, bad, 0, 0, "rem0_w1");
    check("sat_hold_err_count", {24'd0, err_count}, 32'd255);

    // Channel drop mid-frame, then a clean 3-word frame.
    do_reset();
    beat(1, 0, 0, 1, 16'h0000, 0, 1, "cu_pre");
    beat(1, 1, 0, 1, l0, 0, 0, "cu_w0");
    beat(1, 0, 0, 1, l1, 0, 0, "cu_w1");
    chan_up = 1'b0;
    beat(1, 0, 0, 1, 16'hDEAD, 0, 0, "cu_down0");
    beat(1, 1, 1, 1, 16'hBEEF, 0, 0, "cu_down1");
    beat(1, 0, 1, 1, 16'h0000, 0, 0, "cu_down2");
    check("cu_down_err_count", {24'd0, err_count}, 32'd1);
    chan_up = 1'b1;
    beat(1, 1, 0, 1, l0, 0, 0, "cu_f0");
    beat(1, 0, 0, 1, l1, 0, 0, "cu_f1");
    beat(1, 0, 1, 1, l2, 0, 0, "cu_f2");
    check("cu_err_count", {24'd0, err_count}, 32'd1);
`ifdef FRAME_CHK_STATS_EN
    check("cu_frame_count", {16'd0, frame_count}, 32'd1);
    check("cu_last_len", {16'd0, last_len}, 32'd3);
`endif

    // Reset in the middle of a frame: the rest of that frame is unframed.
    beat(1, 1, 0, 1, l0, 0, 0, "rm_w0");
    do_reset();
    check("rm_err_count", {24'd0, err_count}, 32'd0);
    beat(1, 0, 0, 1, l1, 0, 1, "rm_w1");
    beat(1, 0, 1, 1, l2, 0, 1, "rm_w2");
    check("rm_err_count_after", {24'd0, err_count}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
